// File: rtl/csc_expand_if.sv
// csc_expand_if: groups the descriptor input, the element output stream and the
// status outputs of csc_expand. The slave modport is the expander's view and the
// master modport is the surrounding environment's view.
interface csc_expand_if #(
    parameter int IDX_W = 8
);
    // descriptor from the upstream generator
    logic [4*IDX_W-1:0] Scol_index;
    logic [31:0]        S_val_i0;
    logic [31:0]        S_val_i1;
    logic [31:0]        S_val_i2;
    logic [31:0]        S_val_i3;
    logic [31:0]        S_val_r0;
    logic [31:0]        S_val_r1;
    logic [31:0]        S_val_r2;
    logic [31:0]        S_val_r3;
    logic [2:0]         S_nnz;
    logic               S_vld_o;
    logic               S_rdy_o;
    // expanded element stream
    logic [IDX_W-1:0]   e_row;
    logic [IDX_W-1:0]   e_col;
    logic [31:0]        e_val_i;
    logic [31:0]        e_val_r;
    logic               e_last_row;
    logic               e_last;
    logic               e_vld;
    logic               e_rdy;
    // status
    logic               err_o;
    logic [15:0]        mat_cnt;

    modport slave (
        input  Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        input  S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_nnz, S_vld_o,
        output S_rdy_o,
        output e_row, e_col, e_val_i, e_val_r, e_last_row, e_last, e_vld,
        input  e_rdy,
        output err_o, mat_cnt
    );

    modport master (
        output Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        output S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_nnz, S_vld_o,
        input  S_rdy_o,
        input  e_row, e_col, e_val_i, e_val_r, e_last_row, e_last, e_vld,
        output e_rdy,
        input  err_o, mat_cnt
    );
endinterface

// File: rtl/csc_expand.sv
// csc_expand: expands a circulant-matrix descriptor (up to four first-row
// nonzeros) into a stream of every nonzero, row by row, one element per cycle.
// Optional feature: define CSC_EXPAND_MATCNT_EN to build the completed-matrix
// counter on mat_cnt; without it mat_cnt is tied to zero.
module csc_expand #(
    parameter int MAT_RANK = 256,
    parameter int IDX_W    = $clog2(MAT_RANK)
) (
    input  logic         clk,
    input  logic         rst_n,
    csc_expand_if.slave  bus
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_EMIT  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_RANK - 1);

    // unpacked view of the incoming descriptor
    logic [IDX_W-1:0] in_idx   [4];
    logic [31:0]      in_val_r [4];
    logic [31:0]      in_val_i [4];
    logic [1:0]       in_nnz_last;
    logic [3:0]       idx_bad;

    assign in_val_r[0] = bus.S_val_r0;
    assign in_val_r[1] = bus.S_val_r1;
    assign in_val_r[2] = bus.S_val_r2;
    assign in_val_r[3] = bus.S_val_r3;
    assign in_val_i[0] = bus.S_val_i0;
    assign in_val_i[1] = bus.S_val_i1;
    assign in_val_i[2] = bus.S_val_i2;
    assign in_val_i[3] = bus.S_val_i3;

    // state and registered outputs
    logic [0:0]       state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             last_row_q, last_row_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_out_q, col_out_d;
    logic [31:0]      val_r_out_q, val_r_out_d;
    logic [31:0]      val_i_out_q, val_i_out_d;
    // latched descriptor; col_q[k] tracks slot k's column on the current row
    logic [1:0]       slot_q, slot_d;
    logic [1:0]       nnz_last_q, nnz_last_d;
    logic [IDX_W-1:0] col_q   [4];
    logic [IDX_W-1:0] col_d   [4];
    logic [IDX_W-1:0] col_inc [4];
    logic [31:0]      val_r_q [4];
    logic [31:0]      val_r_d [4];
    logic [31:0]      val_i_q [4];
    logic [31:0]      val_i_d [4];
    logic [1:0]       slot_nx;

    assign slot_nx = slot_q + 2'd1;

    // per-slot index extraction, range check and modular column increment
    // (wrap by compare so non-power-of-two ranks never overflow)
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign in_idx[gi]  = bus.Scol_index[gi*IDX_W +: IDX_W];
        assign idx_bad[gi] = (2'(gi) <= in_nnz_last) &&
                             ({1'b0, in_idx[gi]} >= (IDX_W+1)'(MAT_RANK));
        assign col_inc[gi] = (col_q[gi] == LAST_IDX) ? '0 : col_q[gi] + IDX_W'(1);
    end

    // effective nnz minus one: codes 0..2 mean 2, 3 means 3, 4..7 mean 4
    always_comb begin
        case (bus.S_nnz)
            3'd0, 3'd1, 3'd2: in_nnz_last = 2'd1;
            3'd3:             in_nnz_last = 2'd2;
            default:          in_nnz_last = 2'd3;
        endcase
    end

    // next-state: accept/drop descriptors in IDLE, advance the element in EMIT
    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        err_d       = 1'b0;
        vld_d       = vld_q;
        last_d      = last_q;
        last_row_d  = last_row_q;
        row_d       = row_q;
        col_out_d   = col_out_q;
        val_r_out_d = val_r_out_q;
        val_i_out_d = val_i_out_q;
        slot_d      = slot_q;
        nnz_last_d  = nnz_last_q;
        for (int k = 0; k < 4; k++) begin
            col_d[k]   = col_q[k];
            val_r_d[k] = val_r_q[k];
            val_i_d[k] = val_i_q[k];
        end
        rdy_d = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (rdy_q && bus.S_vld_o) begin
                    if (|idx_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ST_EMIT;
                        rdy_d       = 1'b0;
                        vld_d       = 1'b1;
                        row_d       = '0;
                        slot_d      = 2'd0;
                        nnz_last_d  = in_nnz_last;
                        col_out_d   = in_idx[0];
                        val_r_out_d = in_val_r[0];
                        val_i_out_d = in_val_i[0];
                        last_row_d  = 1'b0;
                        last_d      = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            col_d[k]   = in_idx[k];
                            val_r_d[k] = in_val_r[k];
                            val_i_d[k] = in_val_i[k];
                        end
                    end
                end
            end
            default: begin
                if (vld_q && bus.e_rdy) begin
                    if (last_q) begin
                        state_d    = ST_IDLE;
                        rdy_d      = 1'b1;
                        vld_d      = 1'b0;
                        last_d     = 1'b0;
                        last_row_d = 1'b0;
                    end else if (last_row_q) begin
                        // nnz >= 2, so slot 0 of a new row is never row-last
                        row_d       = row_q + IDX_W'(1);
                        slot_d      = 2'd0;
                        col_out_d   = col_inc[0];
                        val_r_out_d = val_r_q[0];
                        val_i_out_d = val_i_q[0];
                        last_row_d  = 1'b0;
                        last_d      = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            col_d[k] = col_inc[k];
                        end
                    end else begin
                        slot_d      = slot_nx;
                        col_out_d   = col_q[slot_nx];
                        val_r_out_d = val_r_q[slot_nx];
                        val_i_out_d = val_i_q[slot_nx];
                        last_row_d  = (slot_nx == nnz_last_q);
                        last_d      = (slot_nx == nnz_last_q) && (row_q == LAST_IDX);
                    end
                end
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            last_row_q  <= 1'b0;
            row_q       <= '0;
            col_out_q   <= '0;
            val_r_out_q <= '0;
            val_i_out_q <= '0;
            slot_q      <= 2'd0;
            nnz_last_q  <= 2'd1;
            for (int k = 0; k < 4; k++) begin
                col_q[k]   <= '0;
                val_r_q[k] <= '0;
                val_i_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            last_row_q  <= last_row_d;
            row_q       <= row_d;
            col_out_q   <= col_out_d;
            val_r_out_q <= val_r_out_d;
            val_i_out_q <= val_i_out_d;
            slot_q      <= slot_d;
            nnz_last_q  <= nnz_last_d;
            for (int k = 0; k < 4; k++) begin
                col_q[k]   <= col_d[k];
                val_r_q[k] <= val_r_d[k];
                val_i_q[k] <= val_i_d[k];
            end
        end
    end

`ifdef CSC_EXPAND_MATCNT_EN
    logic [15:0] mat_cnt_q, mat_cnt_d;

    // count completed matrices on the final element handshake, wrapping
    always_comb begin
        mat_cnt_d = mat_cnt_q;
        if ((state_q == ST_EMIT) && vld_q && bus.e_rdy && last_q) begin
            mat_cnt_d = mat_cnt_q + 16'd1;
        end
    end

    // matrix counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_cnt_q <= '0;
        end else begin
            mat_cnt_q <= mat_cnt_d;
        end
    end

    assign bus.mat_cnt = mat_cnt_q;
`else
    assign bus.mat_cnt = 16'd0;
`endif

    assign bus.S_rdy_o    = rdy_q;
    assign bus.err_o      = err_q;
    assign bus.e_vld      = vld_q;
    assign bus.e_last     = last_q;
    assign bus.e_last_row = last_row_q;
    assign bus.e_row      = row_q;
    assign bus.e_col      = col_out_q;
    assign bus.e_val_r    = val_r_out_q;
    assign bus.e_val_i    = val_i_out_q;

endmodule

// File: tb/tb_csc_expand.sv
// tb_csc_expand: directed bench for csc_expand with MAT_RANK=16 (IDX_W=5 so an
// out-of-range index of 16 can be presented).
module tb_csc_expand;

    localparam int RANK = 16;
    localparam int IW   = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_mat;

    logic [IW-1:0] obs_col [64];
    logic [31:0]   obs_vr  [64];
    logic          obs_lr  [64];

    csc_expand_if #(.IDX_W(IW)) bus ();

    csc_expand #(.MAT_RANK(RANK), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one descriptor and consume its elements against a row/slot model;
    // rst_at >= 0 aborts with a reset once that many elements have been taken
    task automatic run_matrix(input logic [4*IW-1:0] idx, input logic [2:0] code,
                              input logic [127:0] vr, input logic [127:0] vi,
                              input bit rnd, input int rst_at, input string name);
        int nnz, total, cnt, cyc, r, k;
        bit stalled;
        logic [IW-1:0] s_row, s_col, ec;
        logic [31:0]   s_vr, s_vi;
        logic          s_lr, s_l;
        nnz   = (code <= 3'd2) ? 2 : ((code == 3'd3) ? 3 : 4);
        total = RANK * nnz;
        bus.Scol_index = idx;
        bus.S_nnz      = code;
        bus.S_val_r0 = vr[31:0];   bus.S_val_r1 = vr[63:32];
        bus.S_val_r2 = vr[95:64];  bus.S_val_r3 = vr[127:96];
        bus.S_val_i0 = vi[31:0];   bus.S_val_i1 = vi[63:32];
        bus.S_val_i2 = vi[95:64];  bus.S_val_i3 = vi[127:96];
        bus.S_vld_o  = 1'b1;
        bus.e_rdy    = 1'b1;
        cyc = 0;
        while (!bus.S_rdy_o && cyc < 50) begin
            step();
            cyc++;
        end
        chk({name, "_accept_rdy"}, bus.S_rdy_o, 1);
        step();
        bus.S_vld_o = 1'b0;
        chk({name, "_first_vld"}, bus.e_vld, 1);
        cnt = 0; cyc = 0; stalled = 0;
        s_row = '0; s_col = '0; s_vr = '0; s_vi = '0; s_lr = 0; s_l = 0;
        while (cnt < total && cyc < 4000) begin
            if (rst_at >= 0 && cnt == rst_at) break;
            if (stalled) begin
                chk({name, "_hold_row"}, bus.e_row, s_row);
                chk({name, "_hold_col"}, bus.e_col, s_col);
                chk({name, "_hold_vr"}, bus.e_val_r, s_vr);
                chk({name, "_hold_vi"}, bus.e_val_i, s_vi);
                chk({name, "_hold_lr"}, bus.e_last_row, s_lr);
                chk({name, "_hold_l"}, bus.e_last, s_l);
            end
            chk({name, "_vld"}, bus.e_vld, 1);
            bus.e_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.e_vld && bus.e_rdy) begin
                r  = cnt / nnz;
                k  = cnt % nnz;
                ec = IW'((int'(idx[k*IW +: IW]) + r) % RANK);
                chk({name, "_row"}, bus.e_row, IW'(r));
                chk({name, "_col"}, bus.e_col, ec);
                chk({name, "_vr"}, bus.e_val_r, vr[k*32 +: 32]);
                chk({name, "_vi"}, bus.e_val_i, vi[k*32 +: 32]);
                chk({name, "_last_row"}, bus.e_last_row, (k == nnz - 1));
                chk({name, "_last"}, bus.e_last, (k == nnz - 1) && (r == RANK - 1));
                obs_col[cnt] = bus.e_col;
                obs_vr[cnt]  = bus.e_val_r;
                obs_lr[cnt]  = bus.e_last_row;
                cnt++;
                stalled = 0;
            end else begin
                stalled = bus.e_vld;
                s_row = bus.e_row;    s_col = bus.e_col;
                s_vr  = bus.e_val_r;  s_vi  = bus.e_val_i;
                s_lr  = bus.e_last_row; s_l = bus.e_last;
            end
            step();
            cyc++;
        end
        bus.e_rdy = 1'b1;
        if (rst_at >= 0) begin
            chk({name, "_pre_reset_cnt"}, cnt, rst_at);
            rst_n = 1'b0;
            #1;
            chk({name, "_rst_vld"}, bus.e_vld, 0);
            chk({name, "_rst_rdy"}, bus.S_rdy_o, 0);
            chk({name, "_rst_last"}, bus.e_last, 0);
            chk({name, "_rst_col"}, bus.e_col, 0);
            exp_mat = 0;
            step();
            step();
            rst_n = 1'b1;
            step();
            chk({name, "_rel_rdy"}, bus.S_rdy_o, 1);
            chk({name, "_rel_vld"}, bus.e_vld, 0);
            step();
            chk({name, "_idle_vld"}, bus.e_vld, 0);
            chk({name, "_mat_cnt_rst"}, bus.mat_cnt, 0);
            $display("xact %s aborted by reset after %0d elements", name, cnt);
        end else begin
            chk({name, "_elem_count"}, cnt, total);
            chk({name, "_done_vld"}, bus.e_vld, 0);
            chk({name, "_done_rdy"}, bus.S_rdy_o, 1);
`ifdef CSC_EXPAND_MATCNT_EN
            exp_mat++;
`endif
            chk({name, "_mat_cnt"}, bus.mat_cnt, 64'(exp_mat));
            $display("xact %s nnz=%0d elements=%0d", name, nnz, cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; exp_mat = 0;
        rst_n = 1'b0;
        bus.Scol_index = '0; bus.S_nnz = '0; bus.S_vld_o = 1'b0; bus.e_rdy = 1'b0;
        bus.S_val_r0 = '0; bus.S_val_r1 = '0; bus.S_val_r2 = '0; bus.S_val_r3 = '0;
        bus.S_val_i0 = '0; bus.S_val_i1 = '0; bus.S_val_i2 = '0; bus.S_val_i3 = '0;
        step();
        step();
        // reset state
        chk("rst_rdy", bus.S_rdy_o, 0);
        chk("rst_vld", bus.e_vld, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_last", bus.e_last, 0);
        chk("rst_last_row", bus.e_last_row, 0);
        chk("rst_row", bus.e_row, 0);
        chk("rst_col", bus.e_col, 0);
        chk("rst_vr", bus.e_val_r, 0);
        chk("rst_vi", bus.e_val_i, 0);
        chk("rst_mat_cnt", bus.mat_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("rel_rdy", bus.S_rdy_o, 1);
        $display("xact reset released");

        // nnz=2, indices {3,9}
        run_matrix({5'd0, 5'd0, 5'd9, 5'd3}, 3'd1,
                   {32'h0, 32'h0, 32'hBEEF0002, 32'hCAFE0001},
                   {32'h0, 32'h0, 32'h11112222, 32'h33334444}, 1'b0, -1, "t1");
        chk("t1_r0_c0", obs_col[0], 3);
        chk("t1_r0_c1", obs_col[1], 9);
        chk("t1_r7_c0", obs_col[14], 10);
        chk("t1_r7_c1", obs_col[15], 0);

        // nnz=4, indices {0,5,10,15}, r0=0x00010000
        run_matrix({5'd15, 5'd10, 5'd5, 5'd0}, 3'd4,
                   {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'h00010000},
                   {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, -1, "t2");
        chk("t2_r1_c0", obs_col[4], 1);
        chk("t2_r1_c1", obs_col[5], 6);
        chk("t2_r1_c2", obs_col[6], 11);
        chk("t2_r1_c3", obs_col[7], 0);
        chk("t2_r9_vr0", obs_vr[36], 32'h00010000);
        chk("t2_r15_vr0", obs_vr[60], 32'h00010000);
        chk("t2_lr3", obs_lr[3], 1);
        chk("t2_lr2", obs_lr[2], 0);
        chk("t2_lr63", obs_lr[63], 1);

        // nnz code 7 (=4) with random back-pressure
        run_matrix({5'd11, 5'd7, 5'd14, 5'd2}, 3'd7,
                   {32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0},
                   {32'h50505053, 32'h50505052, 32'h50505051, 32'h50505050}, 1'b1, -1, "t3");

        // out-of-range slot 1 index is dropped with one err pulse
        bus.Scol_index = {5'd0, 5'd0, 5'd16, 5'd2};
        bus.S_nnz = 3'd2;
        bus.S_vld_o = 1'b1;
        chk("drop_rdy_before", bus.S_rdy_o, 1);
        step();
        bus.S_vld_o = 1'b0;
        chk("drop_err_pulse", bus.err_o, 1);
        chk("drop_vld", bus.e_vld, 0);
        chk("drop_rdy", bus.S_rdy_o, 1);
        step();
        chk("drop_err_clear", bus.err_o, 0);
        chk("drop_vld2", bus.e_vld, 0);
        chk("drop_rdy2", bus.S_rdy_o, 1);
        $display("xact drop index=16 err pulsed");

        // nnz=3; inactive slot 3 carries an out-of-range index that must be ignored
        run_matrix({5'd31, 5'd4, 5'd13, 5'd15}, 3'd3,
                   {32'h0, 32'h00000033, 32'h00000022, 32'h00000011},
                   {32'h0, 32'h00000066, 32'h00000055, 32'h00000044}, 1'b0, -1, "t4");

        // reset at element 10
        run_matrix({5'd0, 5'd0, 5'd12, 5'd1}, 3'd0,
                   {32'h0, 32'h0, 32'h77770002, 32'h77770001},
                   {32'h0, 32'h0, 32'h88880002, 32'h88880001}, 1'b0, 10, "t5");

        // three back-to-back matrices after reset
        run_matrix({5'd0, 5'd0, 5'd6, 5'd8}, 3'd2,
                   {32'h0, 32'h0, 32'h00000B02, 32'h00000B01},
                   {32'h0, 32'h0, 32'h00000C02, 32'h00000C01}, 1'b0, -1, "b1");
        run_matrix({5'd3, 5'd2, 5'd1, 5'd0}, 3'd5,
                   {32'h000D0004, 32'h000D0003, 32'h000D0002, 32'h000D0001},
                   {32'h000E0004, 32'h000E0003, 32'h000E0002, 32'h000E0001}, 1'b0, -1, "b2");
        run_matrix({5'd9, 5'd15, 5'd0, 5'd14}, 3'd6,
                   {32'hF0000004, 32'hF0000003, 32'hF0000002, 32'hF0000001},
                   {32'h0F000004, 32'h0F000003, 32'h0F000002, 32'h0F000001}, 1'b0, -1, "b3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
